// File: rtl/switch_glyph_selector.sv
// Slide-switch glyph selector: synchronizes and debounces a switch bank, then
// commits the settled value as a glyph code and its font-memory offset,
// optionally deferred to the next vertical-blanking strobe so the displayed
// glyph never changes mid-frame.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | switches match the committed code, nothing in flight
// SETTLING | counting consecutive equal samples of a candidate value
// PENDING  | candidate debounced, waiting for frame_sync to commit it
module switch_glyph_selector #(
  parameter int unsigned SW_WIDTH        = 4,
  parameter int unsigned OFFSET_WIDTH    = 13,
  parameter int unsigned GLYPH_LOG2      = 9,
  parameter int unsigned BASE_OFFSET     = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          FRAME_SYNC_EN   = 1'b1
) (
  input  logic                    clk_50MHz,
  input  logic                    reset_n,
  input  logic [SW_WIDTH-1:0]     switch_bus,
  input  logic                    frame_sync,
  output logic [OFFSET_WIDTH-1:0] offset,
  output logic [SW_WIDTH-1:0]     code,
  output logic                    offset_update,
  output logic                    busy
);

  // cnt only ever climbs to DEBOUNCE_CYCLES-1 before completion, so this
  // width can never wrap.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Wide enough that base + code * stride is formed without truncation
  // before the final modulo.
  localparam int unsigned FULL_W = OFFSET_WIDTH + SW_WIDTH + GLYPH_LOG2 + 32;
  localparam logic [OFFSET_WIDTH-1:0] RST_OFFSET = OFFSET_WIDTH'(BASE_OFFSET);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    PENDING  = 2'd2
  } state_t;

  state_t              state;
  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;
  logic [SW_WIDTH-1:0] cand;
  logic [CNT_W-1:0]    cnt;

  function automatic logic [OFFSET_WIDTH-1:0] glyph_offset(input logic [SW_WIDTH-1:0] v);
    return OFFSET_WIDTH'(FULL_W'(BASE_OFFSET) + (FULL_W'(v) << GLYPH_LOG2));
  endfunction

  // Two-flop synchronizer; the only place switch_bus is sampled.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch_bus;
      sw_sync <= sw_meta;
    end
  end

  // Debounce / commit FSM with registered outputs.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cand          <= '0;
      cnt           <= '0;
      code          <= '0;
      offset        <= RST_OFFSET;
      offset_update <= 1'b0;
      busy          <= 1'b0;
    end else begin
      offset_update <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sw_sync != code) begin
            cand <= sw_sync;
            cnt  <= CNT_ONE;
            if (DEBOUNCE_CYCLES <= 1) begin
              // The entry sample alone completes the debounce.
              if (FRAME_SYNC_EN) begin
                state <= PENDING;
                busy  <= 1'b1;
              end else begin
                code          <= sw_sync;
                offset        <= glyph_offset(sw_sync);
                offset_update <= 1'b1;
                state         <= IDLE;
                busy          <= 1'b0;
              end
            end else begin
              state <= SETTLING;
              busy  <= 1'b1;
            end
          end
        end
        SETTLING: begin
          if (sw_sync != cand) begin
            cand <= sw_sync;
            cnt  <= CNT_ONE;
          end else if (cnt >= CNT_LAST) begin
            if (cand == code) begin
              // Input bounced back to the committed value.
              state <= IDLE;
              busy  <= 1'b0;
            end else if (FRAME_SYNC_EN) begin
              state <= PENDING;
            end else begin
              code          <= cand;
              offset        <= glyph_offset(cand);
              offset_update <= 1'b1;
              state         <= IDLE;
              busy          <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PENDING: begin
          // A strobe wins over a simultaneous switch change; the change is
          // picked up again from IDLE.
          if (frame_sync) begin
            code          <= cand;
            offset        <= glyph_offset(cand);
            offset_update <= 1'b1;
            state         <= IDLE;
            busy          <= 1'b0;
          end else if (sw_sync != cand) begin
            cand  <= sw_sync;
            cnt   <= CNT_ONE;
            state <= SETTLING;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_glyph_selector.sv
// Bench for switch_glyph_selector: three instances (debounce 4 immediate,
// debounce 4 frame-synced, debounce 1 immediate) with a commit scoreboard.
module tb_switch_glyph_selector;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  sw0 = 4'h0;
  logic [3:0]  sw1 = 4'h0;
  logic        fs = 1'b0;
  logic [12:0] off0, off1, off2;
  logic [3:0]  code0, code1, code2;
  logic        upd0, upd1, upd2;
  logic        busy0, busy1, busy2;

  always #5 clk = ~clk;

  switch_glyph_selector #(.DEBOUNCE_CYCLES(4), .FRAME_SYNC_EN(1'b0)) dut0 (
    .clk_50MHz(clk), .reset_n(reset_n), .switch_bus(sw0), .frame_sync(1'b0),
    .offset(off0), .code(code0), .offset_update(upd0), .busy(busy0));

  switch_glyph_selector #(.DEBOUNCE_CYCLES(4), .FRAME_SYNC_EN(1'b1)) dut1 (
    .clk_50MHz(clk), .reset_n(reset_n), .switch_bus(sw1), .frame_sync(fs),
    .offset(off1), .code(code1), .offset_update(upd1), .busy(busy1));

  switch_glyph_selector #(.DEBOUNCE_CYCLES(1), .FRAME_SYNC_EN(1'b0)) dut2 (
    .clk_50MHz(clk), .reset_n(reset_n), .switch_bus(sw0), .frame_sync(1'b0),
    .offset(off2), .code(code2), .offset_update(upd2), .busy(busy2));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  c;
    logic [12:0] o;
  } exp_t;

  typedef struct {
    logic [3:0]  sw;
    logic [12:0] off;
    int          lat0;
    int          lat2;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  logic        prev_upd [3];
  logic [12:0] last_off [3];
  logic        a00_seen = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [3:0] c, input logic [12:0] o);
    exp_t e;
    e.c = c;
    e.o = o;
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Pops one expectation per observed pulse; flags wide pulses, pulses with
  // nothing expected, and offset changes without a pulse.
  task automatic mon(input int id, input logic upd, input logic [3:0] c, input logic [12:0] o);
    exp_t e;
    int   n;
    if (upd) begin
      chk($sformatf("pulse_width_%0d", id), 32'(prev_upd[id]), 0);
      case (id)
        0: n = q0.size();
        1: n = q1.size();
        default: n = q2.size();
      endcase
      if (n == 0) begin
        chk($sformatf("unexpected_pulse_%0d", id), 1, 0);
      end else begin
        case (id)
          0: e = q0.pop_front();
          1: e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        chk($sformatf("commit_code_%0d", id), 32'(c), 32'(e.c));
        chk($sformatf("commit_offset_%0d", id), 32'(o), 32'(e.o));
      end
    end else if (o != last_off[id]) begin
      chk($sformatf("silent_offset_change_%0d", id), 32'(o), 32'(last_off[id]));
    end
    prev_upd[id] = upd;
    last_off[id] = o;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) prev_upd[i] = 1'b0;
      last_off[0] = off0;
      last_off[1] = off1;
      last_off[2] = off2;
    end else begin
      mon(0, upd0, code0, off0);
      mon(1, upd1, code1, off1);
      mon(2, upd2, code2, off2);
      if (off1 == 13'hA00) a00_seen = 1'b1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Counts edges from the current negedge to the first pulse of dut0/dut2;
  // -1 means the pulse never arrived within the budget.
  task automatic wait_pulses(input int budget, output int l0, output int l2);
    l0 = -1;
    l2 = -1;
    for (int e = 1; e <= budget; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (upd0 && l0 < 0) l0 = e;
      if (upd2 && l2 < 0) l2 = e;
    end
  endtask

  task automatic fs_pulse();
    fs = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fs = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int   l0, l2;

    vecs[0] = '{sw: 4'hA, off: 13'h1400, lat0: 6, lat2: 3};
    vecs[1] = '{sw: 4'h3, off: 13'h0600, lat0: 6, lat2: 3};
    vecs[2] = '{sw: 4'hF, off: 13'h1E00, lat0: 6, lat2: 3};
    vecs[3] = '{sw: 4'h9, off: 13'h1200, lat0: 6, lat2: 3};
    vecs[4] = '{sw: 4'h5, off: 13'h0A00, lat0: 6, lat2: 3};
    vecs[5] = '{sw: 4'h0, off: 13'h0000, lat0: 6, lat2: 3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_offset0", 32'(off0), 0);
    chk("rst_code0", 32'(code0), 0);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_upd0", 32'(upd0), 0);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_offset2", 32'(off2), 0);
    reset_n = 1'b1;
    cycles(3);

    // Clean changes, immediate commit: latency 2+DEBOUNCE_CYCLES
    foreach (vecs[i]) begin
      sw0 = vecs[i].sw;
      push(0, vecs[i].sw, vecs[i].off);
      push(2, vecs[i].sw, vecs[i].off);
      wait_pulses(12, l0, l2);
      chk($sformatf("vec%0d_lat0", i), 32'(l0), 32'(vecs[i].lat0));
      chk($sformatf("vec%0d_lat2", i), 32'(l2), 32'(vecs[i].lat2));
      chk($sformatf("vec%0d_code0", i), 32'(code0), 32'(vecs[i].sw));
      chk($sformatf("vec%0d_offset0", i), 32'(off0), 32'(vecs[i].off));
      chk($sformatf("vec%0d_busy0", i), 32'(busy0), 0);
      chk($sformatf("vec%0d_code2", i), 32'(code2), 32'(vecs[i].sw));
    end

    // Toggling 0->3->0->3 every 2 cycles, then hold 3
    push(2, 4'h3, 13'h600);
    push(2, 4'h0, 13'h000);
    push(2, 4'h3, 13'h600);
    sw0 = 4'h3;
    cycles(2);
    sw0 = 4'h0;
    cycles(2);
    chk("toggle_busy0", 32'(busy0), 1);
    chk("toggle_no_commit", 32'(off0), 0);
    sw0 = 4'h3;
    push(0, 4'h3, 13'h600);
    wait_pulses(12, l0, l2);
    chk("toggle_lat0", 32'(l0), 6);
    chk("toggle_offset0", 32'(off0), 32'h600);

    // Short excursion that bounces back to the committed value
    push(2, 4'h0, 13'h000);
    push(2, 4'h3, 13'h600);
    sw0 = 4'h0;
    cycles(2);
    sw0 = 4'h3;
    cycles(12);
    chk("bounce_busy0", 32'(busy0), 0);
    chk("bounce_code0", 32'(code0), 3);

    // Frame-synced commit held off by a late strobe
    sw1 = 4'hF;
    cycles(26);
    chk("pend_busy1", 32'(busy1), 1);
    chk("pend_offset1", 32'(off1), 0);
    chk("pend_code1", 32'(code1), 0);
    push(1, 4'hF, 13'h1E00);
    fs_pulse();
    chk("fs_upd1", 32'(upd1), 1);
    chk("fs_offset1", 32'(off1), 32'h1E00);
    chk("fs_busy1", 32'(busy1), 0);

    // Pending value replaced before any strobe
    sw1 = 4'h5;
    cycles(8);
    chk("repl_busy_a", 32'(busy1), 1);
    sw1 = 4'h6;
    cycles(12);
    chk("repl_busy_b", 32'(busy1), 1);
    chk("repl_offset_hold", 32'(off1), 32'h1E00);
    chk("repl_code_hold", 32'(code1), 32'hF);
    push(1, 4'h6, 13'hC00);
    fs_pulse();
    chk("repl_upd1", 32'(upd1), 1);
    chk("repl_offset1", 32'(off1), 32'hC00);
    chk("repl_no_a00", 32'(a00_seen), 0);

    // Strobe coincides with a synchronized switch change in PENDING
    sw1 = 4'h7;
    cycles(8);
    chk("coin_busy_a", 32'(busy1), 1);
    push(1, 4'h7, 13'hE00);
    sw1 = 4'h8;
    cycles(2);
    fs_pulse();
    chk("coin_upd1", 32'(upd1), 1);
    chk("coin_code1", 32'(code1), 7);
    cycles(1);
    chk("coin_redebounce_busy", 32'(busy1), 1);
    cycles(5);
    push(1, 4'h8, 13'h1000);
    fs_pulse();
    chk("coin2_code1", 32'(code1), 8);
    chk("coin2_offset1", 32'(off1), 32'h1000);

    // Reset pulsed mid-SETTLING
    sw0 = 4'h9;
    push(2, 4'h9, 13'h1200);
    cycles(4);
    chk("mid_busy0", 32'(busy0), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_offset0", 32'(off0), 0);
    chk("async_code0", 32'(code0), 0);
    chk("async_busy0", 32'(busy0), 0);
    chk("async_upd0", 32'(upd0), 0);
    chk("async_busy1", 32'(busy1), 0);
    @(negedge clk);
    cycles(2);
    reset_n = 1'b1;
    push(0, 4'h9, 13'h1200);
    push(2, 4'h9, 13'h1200);
    wait_pulses(12, l0, l2);
    chk("post_rst_lat0", 32'(l0), 6);
    chk("post_rst_lat2", 32'(l2), 3);
    chk("post_rst_offset0", 32'(off0), 32'h1200);

    cycles(2);
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q2_drained", 32'(q2.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
